concat_repl_arbiter: RTL
========================

// Module: concat_repl_arbiter
// PURPOSE
//  Shares one concatenate/replicate unit between two requesters. Each requester
//  presents operands a[3:0], b[1:0] and an op code under valid/ready. A
//  round-robin arbiter grants one request per cycle. The result is registered
//  and returned under a valid/ready handshake, tagged with the requester id.
//  The block sits between the numbers-library stimulus ports and one shared unit.
// PARAMETERS
//  CNT_W   8   width of the per-requester accepted-transaction counters
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  req_valid   in   2      per-requester request valid (bit i = requester i)
//  req_ready   out  2      per-requester accept; at most one bit high per cycle
//  req_a       in   8      {a1[3:0], a0[3:0]}
//  req_b       in   4      {b1[1:0], b0[1:0]}
//  req_op      in   4      {op1[1:0], op0[1:0]}
//  out_valid   out  1      result register holds a valid result
//  out_ready   in   1      downstream accepts the result
//  out_data    out  8      result
//  out_id      out  1      requester that issued the result
//  out_err     out  1      result came from an illegal op
//  cnt0        out  CNT_W  accepted requests from requester 0
//  cnt1        out  CNT_W  accepted requests from requester 1
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0,
//   out_err=0, cnt0=cnt1=0, last_grant=1, so requester 0 wins the first tie.
//  FSM: EMPTY (result register free) / FULL (result held).
//   EMPTY: accept the granted request -> FULL.
//   FULL & out_ready & granted request -> stay FULL with the new result.
//   FULL & out_ready & no request -> EMPTY. FULL & !out_ready -> hold everything.
//  Accept condition: can_accept = (state==EMPTY) | out_ready.
//   req_ready[i] = can_accept & grant[i]. Ready depends on valid; no comb path
//   from out_ready to out_data.
//  Grant: one valid -> that one. Both valid -> the requester != last_grant.
//   last_grant updates only on an accepted transfer.
//  Latency: request accepted at edge N -> out_valid=1 with its result after N.
//   Throughput is 1 result/cycle while out_ready=1.
//  Ops (computed on the granted operands a, b):
//   0 CAT  : out_data = {2'b00, a, b}
//   1 REPA : out_data = {a, a}
//   2 REPB : out_data = {2'b00, b, b, b}
//   3 illegal: out_data = 8'h00, out_err = 1. Ops 0-2 give out_err = 0.
//  Stall: while FULL & !out_ready, out_data, out_id and out_err are stable and
//   req_ready = 2'b00.
//  Counters: cnt<i> increments by 1 on each accepted transfer from requester i.
//   Counters wrap 2^CNT_W-1 -> 0. No counter increments for a stalled request.
//  Requests are not latched: a requester may drop valid before ready and lose
//   nothing. Operands are sampled only in the accept cycle.
//  Reset mid-transfer discards a held result. The reset values above apply.
// TESTING
//  1 Reset, req0 a=4'hA b=2'b01 op=0, out_ready=1 -> next cycle out_data=8'h29,
//    out_id=0, cnt0=1.
//  2 Both valid every cycle: r0 a=3 op=1, r1 b=2'b10 op=2, out_ready=1 ->
//    results alternate 8'h33 (id0), 8'h2A (id1). Requester 0 goes first.
//  3 Hold out_ready=0 for 5 cycles with both valid -> req_ready=0, output
//    stable, counters frozen. On release, id alternation resumes.
//  4 op=3 from r1 -> out_data=8'h00, out_err=1, cnt1 increments. A following
//    op=0 gives out_err=0.
//  5 Drive 256 accepts from r0 with CNT_W=8 -> cnt0 wraps to 0, cnt1 stays 0.
//  6 Assert rst_n=0 while FULL and stalled -> out_valid drops to 0 at once.
//    After release, the tie goes to requester 0.

Source files
------------

// File: rtl/concat_repl_arbiter.sv
// -----------------------------------------------------------------------------
// concat_repl_arbiter
//
// Shares one concatenate/replicate unit between two requesters. A round-robin
// arbiter picks one request per cycle; the selected operands are combined by
// the op code and the result is held in a one-entry output register that is
// drained through a valid/ready handshake and tagged with the requester id.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [1:0] per-requester request valid (bit i = requester i)
//   req_ready  : [1:0] per-requester accept, one-hot or zero
//   req_a      : [7:0] {a1[3:0], a0[3:0]}
//   req_b      : [3:0] {b1[1:0], b0[1:0]}
//   req_op     : [3:0] {op1[1:0], op0[1:0]}
//   out_valid  : result register holds a valid result
//   out_ready  : downstream accepts the result
//   out_data   : [7:0] result
//   out_id     : requester that issued the held result
//   out_err    : held result came from an illegal op
//   cnt0/cnt1  : [CNT_W-1:0] accepted-request counters, wrapping
// -----------------------------------------------------------------------------
module concat_repl_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic [3:0]       req_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_id,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic [1:0]  grant;
  logic        can_accept;
  logic        accept;
  logic        sel;
  logic [3:0]  a_sel;
  logic [1:0]  b_sel;
  logic [1:0]  op_sel;
  logic [7:0]  res_data;
  logic        res_err;

  // Result of the shared unit, packed as {err, data[7:0]}.
  function automatic logic [8:0] compute_op(input logic [3:0] a,
                                            input logic [1:0] b,
                                            input logic [1:0] op);
    logic [8:0] r;
    case (op)
      2'd0:    r = {1'b0, 2'b00, a, b};
      2'd1:    r = {1'b0, a, a};
      2'd2:    r = {1'b0, 2'b00, b, b, b};
      default: r = {1'b1, 8'h00};
    endcase
    return r;
  endfunction

  // Round-robin grant: on a tie the requester that did not win last time goes.
  // last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The register can take a new result when empty, or when the held one is
  // being drained this same cycle.
  assign can_accept = (state == EMPTY) | out_ready;
  assign req_ready  = can_accept ? grant : 2'b00;
  assign accept     = |req_ready;
  assign sel        = req_ready[1];

  assign a_sel  = sel ? req_a[7:4]  : req_a[3:0];
  assign b_sel  = sel ? req_b[3:2]  : req_b[1:0];
  assign op_sel = sel ? req_op[3:2] : req_op[1:0];

  assign {res_err, res_data} = compute_op(a_sel, b_sel, op_sel);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (accept)         state_nxt = FULL;
        else if (out_ready) state_nxt = EMPTY;
        else                state_nxt = FULL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) last_grant <= sel;
    end
  end

  assign out_valid = (state == FULL);

  // Result register: only loaded on an accepted transfer, so it stays stable
  // through a stall and after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 8'h00;
      out_id   <= 1'b0;
      out_err  <= 1'b0;
    end else if (accept) begin
      out_data <= res_data;
      out_id   <= sel;
      out_err  <= res_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (req_ready[0]) cnt0 <= cnt0 + CNT_ONE;
      if (req_ready[1]) cnt1 <= cnt1 + CNT_ONE;
    end
  end

endmodule
